// File: rtl/rtc_bus_seq_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SU,
        A_PW,
        A_HD,
        D_SU,
        D_PW,
        D_HD,
        GAP
    } rtc_state_e;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_T_SU      = 1;
    localparam int DEF_T_PW      = 2;
    localparam int DEF_T_HD      = 1;
    localparam int DEF_T_GAP     = 2;
    localparam int DEF_MAX_BURST = 16;

    // Width of the phase down-counter; wide enough for any practical phase length.
    localparam int TMR_W = 8;

    function automatic logic is_addr_phase(input rtc_state_e s);
        return (s == A_SU) || (s == A_PW) || (s == A_HD);
    endfunction

    function automatic logic is_data_phase(input rtc_state_e s);
        return (s == D_SU) || (s == D_PW) || (s == D_HD);
    endfunction

endpackage

// File: rtl/rtc_bus_seq_if.sv
// Host request/response and multiplexed bus signals of the RTC sequencer.
interface rtc_bus_seq_if #(
    parameter int ADDR_W    = 8,
    parameter int MAX_BURST = 16
);
    localparam int BL_W = $clog2(MAX_BURST + 1);

    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [BL_W-1:0]   burst_len;
    logic [ADDR_W-1:0] wdata;
    logic              wdata_ack;
    logic [ADDR_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic              CS;
    logic              RD;
    logic              WR;
    logic              A_D;
    logic [ADDR_W-1:0] ad_out;
    logic              ad_oe;
    logic [ADDR_W-1:0] ad_in;

    modport master (
        input  start, rw, addr, burst_len, wdata, ad_in,
        output wdata_ack, rdata, rdata_valid, busy, done,
        output CS, RD, WR, A_D, ad_out, ad_oe
    );

    modport slave (
        output start, rw, addr, burst_len, wdata, ad_in,
        input  wdata_ack, rdata, rdata_valid, busy, done,
        input  CS, RD, WR, A_D, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module rtc_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    // Load a new phase length, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)              cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - W'(1);
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/rtc_bus_seq.sv
// RTC multiplexed address/data bus sequencer with burst support.
module rtc_bus_seq
    import rtc_bus_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int T_SU      = DEF_T_SU,
    parameter int T_PW      = DEF_T_PW,
    parameter int T_HD      = DEF_T_HD,
    parameter int T_GAP     = DEF_T_GAP,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic           clk,
    input logic           clr,
    rtc_bus_seq_if.master bus
);
    localparam int BL_W = $clog2(MAX_BURST + 1);

    rtc_state_e        state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              rw_q, rw_n;
    logic [BL_W-1:0]   rem_q, rem_n;
    logic              tmr_load, tmr_tc;
    logic [TMR_W-1:0]  tmr_val;

    logic              cs_q, rd_q, wr_q, ad_q, oe_q;
    logic              cs_n, rd_n, wr_n, ad_n, oe_n;
    logic [ADDR_W-1:0] adout_q, adout_n, rdata_q, rdata_n;
    logic              rv_q, rv_n, wack_q, wack_n, busy_q, busy_n, done_q, done_n;

    rtc_phase_timer #(.W(TMR_W)) u_tmr (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // State and transaction context registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            addr_q <= '0;
            rw_q   <= 1'b0;
            rem_q  <= '0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            rw_q   <= rw_n;
            rem_q  <= rem_n;
        end
    end

    // Next-state sequencing; each phase loads the timer with its length minus one.
    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        rw_n     = rw_q;
        rem_n    = rem_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            IDLE: if (bus.start && bus.burst_len != '0) begin
                state_n  = A_SU;
                addr_n   = bus.addr;
                rw_n     = bus.rw;
                rem_n    = bus.burst_len;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(T_SU - 1);
            end
            A_SU: if (tmr_tc) begin state_n = A_PW; tmr_load = 1'b1; tmr_val = TMR_W'(T_PW - 1);  end
            A_PW: if (tmr_tc) begin state_n = A_HD; tmr_load = 1'b1; tmr_val = TMR_W'(T_HD - 1);  end
            A_HD: if (tmr_tc) begin state_n = D_SU; tmr_load = 1'b1; tmr_val = TMR_W'(T_SU - 1);  end
            D_SU: if (tmr_tc) begin state_n = D_PW; tmr_load = 1'b1; tmr_val = TMR_W'(T_PW - 1);  end
            D_PW: if (tmr_tc) begin state_n = D_HD; tmr_load = 1'b1; tmr_val = TMR_W'(T_HD - 1);  end
            D_HD: if (tmr_tc) begin state_n = GAP;  tmr_load = 1'b1; tmr_val = TMR_W'(T_GAP - 1); end
            GAP: if (tmr_tc) begin
                if (rem_q == BL_W'(1)) begin
                    state_n = IDLE;
                    rem_n   = '0;
                end else begin
                    state_n  = A_SU;
                    rem_n    = rem_q - BL_W'(1);
                    addr_n   = addr_q + ADDR_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(T_SU - 1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        ad_n    = 1'b1;
        oe_n    = 1'b0;
        adout_n = adout_q;
        rdata_n = rdata_q;
        rv_n    = 1'b0;
        wack_n  = 1'b0;
        busy_n  = (state_n != IDLE);
        done_n  = (state == GAP) && (state_n == IDLE);
        if (is_addr_phase(state_n)) begin
            ad_n    = 1'b0;
            oe_n    = 1'b1;
            adout_n = addr_n;
            if (state_n == A_PW) begin
                cs_n = 1'b0;
                wr_n = 1'b0;
            end
        end else if (is_data_phase(state_n)) begin
            if (!rw_n) begin
                oe_n = 1'b1;
                // ad_out doubles as the captured write byte for the rest of the beat.
                if (state == A_HD) begin
                    adout_n = bus.wdata;
                    wack_n  = 1'b1;
                end
                if (state_n == D_PW) begin
                    cs_n = 1'b0;
                    wr_n = 1'b0;
                end
            end else if (state_n == D_PW) begin
                cs_n = 1'b0;
                rd_n = 1'b0;
            end
        end
        if (rw_q && state == D_PW && state_n == D_HD) begin
            rdata_n = bus.ad_in;
            rv_n    = 1'b1;
        end
    end

    // Registered output stage.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            ad_q    <= 1'b1;
            oe_q    <= 1'b0;
            adout_q <= '0;
            rdata_q <= '0;
            rv_q    <= 1'b0;
            wack_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cs_q    <= cs_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            ad_q    <= ad_n;
            oe_q    <= oe_n;
            adout_q <= adout_n;
            rdata_q <= rdata_n;
            rv_q    <= rv_n;
            wack_q  <= wack_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.CS          = cs_q;
    assign bus.RD          = rd_q;
    assign bus.WR          = wr_q;
    assign bus.A_D         = ad_q;
    assign bus.ad_oe       = oe_q;
    assign bus.ad_out      = adout_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rv_q;
    assign bus.wdata_ack   = wack_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_rtc_bus_seq.sv
// Directed bench for rtc_bus_seq with default timing (10-cycle beats).
module tb_rtc_bus_seq;
    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rtc_bus_seq_if #(.ADDR_W(8), .MAX_BURST(16)) bus ();

    rtc_bus_seq #(
        .ADDR_W(8), .T_SU(1), .T_PW(2), .T_HD(1), .T_GAP(2), .MAX_BURST(16)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected {CS,RD,WR,A_D,ad_oe} for cycle p (0..9) of a beat.
    function automatic logic [4:0] phase_exp(input bit rd, input int p);
        case (p)
            0, 3:    return 5'b11101;
            1, 2:    return 5'b01001;
            4, 7:    return rd ? 5'b11110 : 5'b11111;
            5, 6:    return rd ? 5'b00110 : 5'b01011;
            default: return 5'b11110;
        endcase
    endfunction

    function automatic logic [7:0] strobes();
        return 8'({bus.CS, bus.RD, bus.WR, bus.A_D, bus.ad_oe});
    endfunction

    task automatic run_txn(input bit rd, input logic [7:0] a, input int len,
                           input logic [7:0] dbase, input bit poke);
        logic [7:0] ea;
        logic [7:0] ed;
        bus.rw        = rd;
        bus.addr      = a;
        bus.burst_len = 5'(len);
        bus.wdata     = dbase;
        bus.ad_in     = 8'hEE;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int b = 0; b < len; b++) begin
            ea = 8'(a + 8'(b));
            ed = 8'(dbase + 8'(b));
            for (int p = 0; p < 10; p++) begin
                chk8("strobes", strobes(), 8'(phase_exp(rd, p)));
                chk1("busy", bus.busy, 1'b1);
                chk1("done_early", bus.done, 1'b0);
                chk1("wdata_ack", bus.wdata_ack, !rd && p == 4);
                chk1("rdata_valid", bus.rdata_valid, rd && p == 7);
                if (p < 4) chk8("addr_out", bus.ad_out, ea);
                else if (!rd && p < 8) chk8("wdata_out", bus.ad_out, ed);
                if (rd && p == 7) chk8("rdata", bus.rdata, ed);
                // Perturb host/bus inputs outside their capture windows.
                if (p == 4) bus.wdata = ~ed;
                if (p == 6) bus.ad_in = ed;
                if (p == 7) bus.ad_in = 8'hEE;
                if (p == 9) bus.wdata = 8'(ed + 8'd1);
                if (poke && b == 0 && p == 2) begin
                    bus.start = 1'b1; bus.addr = 8'h99; bus.burst_len = 5'd5; bus.rw = ~rd;
                end
                if (poke && b == 0 && p == 3) begin
                    bus.start = 1'b0; bus.rw = rd;
                end
                tick();
            end
        end
        chk1("done", bus.done, 1'b1);
        chk1("busy_end", bus.busy, 1'b0);
        chk8("strobes_idle", strobes(), 8'h1E);
        tick();
        chk1("done_pulse", bus.done, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.burst_len = '0;
        bus.wdata = '0; bus.ad_in = '0;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk8("rst_strobes", strobes(), 8'h1E);
        chk8("rst_ad_out", bus.ad_out, 8'h00);
        chk8("rst_rdata", bus.rdata, 8'h00);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk1("rst_rvalid", bus.rdata_valid, 1'b0);
        chk1("rst_wack", bus.wdata_ack, 1'b0);
        clr = 1'b0;
        tick();

        run_txn(1'b0, 8'h20, 1, 8'h5A, 1'b0);
        run_txn(1'b1, 8'h07, 1, 8'hC3, 1'b0);
        run_txn(1'b1, 8'hFE, 3, 8'h40, 1'b0);

        // Zero-length request is ignored.
        bus.burst_len = 5'd0; bus.addr = 8'h44; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("len0_busy", bus.busy, 1'b0);
            chk1("len0_done", bus.done, 1'b0);
            chk8("len0_strobes", strobes(), 8'h1E);
            tick();
        end

        // Start while busy is ignored: exactly one beat, then idle.
        run_txn(1'b0, 8'h30, 1, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk1("poke_busy", bus.busy, 1'b0);
            tick();
        end

        // Reset during write D_PW.
        bus.rw = 1'b0; bus.addr = 8'h55; bus.burst_len = 5'd2; bus.wdata = 8'h3C;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk8("pre_rst_dpw", strobes(), 8'h0B);
        clr = 1'b1;
        #1;
        chk8("async_rst_strobes", strobes(), 8'h1E);
        chk1("async_rst_busy", bus.busy, 1'b0);
        chk8("async_rst_ad_out", bus.ad_out, 8'h00);
        tick();
        clr = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            chk1("post_rst_done", bus.done, 1'b0);
            chk1("post_rst_busy", bus.busy, 1'b0);
            chk1("post_rst_rvalid", bus.rdata_valid, 1'b0);
        end
        run_txn(1'b1, 8'h10, 2, 8'h77, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
